// File: rtl/morty_clint_if.sv
// Wishbone classic bus bundle for the Morty CLINT register port.
// Signal names keep the slave's view (suffix _i = into the CLINT).
interface morty_clint_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        output wb_adr_i,
        output wb_dat_i,
        output wb_sel_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o
    );

    modport slave (
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_sel_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o
    );
endinterface

// File: rtl/morty_clint.sv
// Morty CLINT: mtime / mtimecmp / msip behind a Wishbone classic slave.
// Registered single-cycle ack/err; mtip is a registered unsigned 64-bit compare.
module morty_clint #(
    parameter int unsigned TICK_DIV    = 1,
    parameter logic [63:0] RESET_MTIME = 64'h0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    morty_clint_if.slave wb,
    output logic         mtip_o,
    output logic         msip_o
);
    localparam logic [15:0] TickLast  = 16'(TICK_DIV - 1);
    localparam logic [2:0]  IdxMsip   = 3'd0;
    localparam logic [2:0]  IdxCmpLo  = 3'd2;
    localparam logic [2:0]  IdxCmpHi  = 3'd3;
    localparam logic [2:0]  IdxTimeLo = 3'd4;
    localparam logic [2:0]  IdxTimeHi = 3'd5;

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdata;
    logic [2:0]  word_idx;
    logic        tick;
    logic        req;
    logic        wr;
    logic        mapped;
    logic        unused_adr;

    function automatic logic [31:0] apply_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign word_idx   = wb.wb_adr_i[4:2];
    assign unused_adr = ^wb.wb_adr_i[1:0];
    // Holding off while ack/err is high limits the port to one access per two cycles.
    assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign wr         = req & wb.wb_we_i;
    assign tick       = (presc_q == TickLast);

    always_comb begin
        mapped = 1'b0;
        rdata  = '0;
        unique case (word_idx)
            IdxMsip: begin
                mapped = 1'b1;
                rdata  = {31'd0, msip_q};
            end
            IdxCmpLo: begin
                mapped = 1'b1;
                rdata  = mtimecmp_q[31:0];
            end
            IdxCmpHi: begin
                mapped = 1'b1;
                rdata  = mtimecmp_q[63:32];
            end
            IdxTimeLo: begin
                mapped = 1'b1;
                rdata  = mtime_q[31:0];
            end
            IdxTimeHi: begin
                mapped = 1'b1;
                rdata  = mtime_q[63:32];
            end
            default: begin
                mapped = 1'b0;
                rdata  = '0;
            end
        endcase
    end

    always_comb begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    // A bus write to either half of mtime swallows that cycle's tick entirely.
    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr && (word_idx == IdxTimeLo)) begin
            mtime_d = {mtime_q[63:32], apply_lanes(mtime_q[31:0], wb.wb_dat_i, wb.wb_sel_i)};
        end else if (wr && (word_idx == IdxTimeHi)) begin
            mtime_d = {apply_lanes(mtime_q[63:32], wb.wb_dat_i, wb.wb_sel_i), mtime_q[31:0]};
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr && (word_idx == IdxCmpLo)) begin
            mtimecmp_d[31:0] = apply_lanes(mtimecmp_q[31:0], wb.wb_dat_i, wb.wb_sel_i);
        end
        if (wr && (word_idx == IdxCmpHi)) begin
            mtimecmp_d[63:32] = apply_lanes(mtimecmp_q[63:32], wb.wb_dat_i, wb.wb_sel_i);
        end
        if (wr && (word_idx == IdxMsip) && wb.wb_sel_i[0]) begin
            msip_d = wb.wb_dat_i[0];
        end
    end

    always_comb begin
        ack_d  = req & mapped;
        err_d  = req & ~mapped;
        dat_d  = dat_q;
        if (req) begin
            dat_d = mapped ? rdata : 32'd0;
        end
        mtip_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            mtime_q    <= RESET_MTIME;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
        end
    end

    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign mtip_o      = mtip_q;
    assign msip_o      = msip_q;
endmodule

// File: tb/tb_morty_clint.sv
// Bench for morty_clint: two instances (TICK_DIV 1 and 4) checked against a
// cycle-level behavioural model of the register map, directed and random.
module tb_morty_clint;
    logic        clk;
    logic        rst;
    logic [1:0]  cyc, stb, we_s;
    logic [4:0]  adr  [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic [31:0] dato [2];
    logic [1:0]  ack, err, mtip, msip;

    morty_clint_if bus0 ();
    morty_clint_if bus1 ();

    assign bus0.wb_cyc_i = cyc[0];
    assign bus0.wb_stb_i = stb[0];
    assign bus0.wb_we_i  = we_s[0];
    assign bus0.wb_adr_i = adr[0];
    assign bus0.wb_dat_i = wdat[0];
    assign bus0.wb_sel_i = sel[0];
    assign dato[0]       = bus0.wb_dat_o;
    assign ack[0]        = bus0.wb_ack_o;
    assign err[0]        = bus0.wb_err_o;
    assign bus1.wb_cyc_i = cyc[1];
    assign bus1.wb_stb_i = stb[1];
    assign bus1.wb_we_i  = we_s[1];
    assign bus1.wb_adr_i = adr[1];
    assign bus1.wb_dat_i = wdat[1];
    assign bus1.wb_sel_i = sel[1];
    assign dato[1]       = bus1.wb_dat_o;
    assign ack[1]        = bus1.wb_ack_o;
    assign err[1]        = bus1.wb_err_o;

    morty_clint #(.TICK_DIV(1), .RESET_MTIME(64'h0)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus0),
        .mtip_o(mtip[0]),
        .msip_o(msip[0])
    );

    morty_clint #(.TICK_DIV(4), .RESET_MTIME(64'h0)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus1),
        .mtip_o(mtip[1]),
        .msip_o(msip[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Behavioural model state, one slot per instance.
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];
    logic        m_mtip  [2];
    logic        m_ack   [2];
    logic        m_err   [2];
    logic [31:0] m_rdata [2];
    int unsigned m_cyc   [2];

    function automatic int unsigned div_of(input int w);
        return (w == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic logic [31:0] word_val(input int w, input logic [2:0] i);
        case (i)
            3'd0:    return {31'd0, m_msip[w]};
            3'd2:    return m_cmp[w][31:0];
            3'd3:    return m_cmp[w][63:32];
            3'd4:    return m_mtime[w][31:0];
            3'd5:    return m_mtime[w][63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input int w);
        logic [63:0] t_n, c_n;
        logic        req_m, map_m;
        logic [2:0]  i;
        if (rst) begin
            m_mtime[w] = 64'h0;
            m_cmp[w]   = '1;
            m_msip[w]  = 1'b0;
            m_mtip[w]  = 1'b0;
            m_ack[w]   = 1'b0;
            m_err[w]   = 1'b0;
            m_rdata[w] = 32'd0;
            m_cyc[w]   = 0;
        end else begin
            i     = adr[w][4:2];
            req_m = cyc[w] && stb[w] && !m_ack[w] && !m_err[w];
            map_m = (i == 3'd0) || (i >= 3'd2 && i <= 3'd5);
            t_n   = ((m_cyc[w] % div_of(w)) == div_of(w) - 1) ? m_mtime[w] + 64'd1 : m_mtime[w];
            c_n   = m_cmp[w];
            m_mtip[w] = (m_mtime[w] >= m_cmp[w]);
            if (req_m) m_rdata[w] = map_m ? word_val(w, i) : 32'd0;
            if (req_m && we_s[w]) begin
                case (i)
                    3'd0: if (sel[w][0]) m_msip[w] = wdat[w][0];
                    3'd2: c_n[31:0]  = merge(m_cmp[w][31:0], wdat[w], sel[w]);
                    3'd3: c_n[63:32] = merge(m_cmp[w][63:32], wdat[w], sel[w]);
                    3'd4: t_n = {m_mtime[w][63:32], merge(m_mtime[w][31:0], wdat[w], sel[w])};
                    3'd5: t_n = {merge(m_mtime[w][63:32], wdat[w], sel[w]), m_mtime[w][31:0]};
                    default: ;
                endcase
            end
            m_ack[w]   = req_m && map_m;
            m_err[w]   = req_m && !map_m;
            m_mtime[w] = t_n;
            m_cmp[w]   = c_n;
            m_cyc[w]   = m_cyc[w] + 1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic bus(input int w, input logic wr, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic ak,
                       output logic er);
        @(negedge clk);
        cyc[w] = 1'b1; stb[w] = 1'b1; we_s[w] = wr; adr[w] = a; wdat[w] = d; sel[w] = s;
        @(posedge clk);
        #1;
        rd = dato[w]; ak = ack[w]; er = err[w];
        @(negedge clk);
        cyc[w] = 1'b0; stb[w] = 1'b0; we_s[w] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        ak, er;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            vecs++; if (ack[w] !== 1'b0) begin errs++; $display("FAIL reset_ack dut%0d: got %b want 0", w, ack[w]); end
            vecs++; if (err[w] !== 1'b0) begin errs++; $display("FAIL reset_err dut%0d: got %b want 0", w, err[w]); end
            vecs++; if (dato[w] !== 32'd0) begin errs++; $display("FAIL reset_dat dut%0d: got %h want 0", w, dato[w]); end
            vecs++; if (mtip[w] !== 1'b0) begin errs++; $display("FAIL reset_mtip dut%0d: got %b want 0", w, mtip[w]); end
            vecs++; if (msip[w] !== 1'b0) begin errs++; $display("FAIL reset_msip dut%0d: got %b want 0", w, msip[w]); end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        bus(0, 1'b0, 5'h10, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (ak !== 1'b1 || er !== 1'b0) begin errs++; $display("FAIL first_ack: got ack=%b err=%b want 1/0", ak, er); end
        vecs++; if (rd !== 32'd10) begin errs++; $display("FAIL mtime_after_10: got %h want %h", rd, 32'd10); end
        vecs++; if (mtip[0] !== 1'b0 || msip[0] !== 1'b0) begin errs++; $display("FAIL irq_idle: got mtip=%b msip=%b want 0/0", mtip[0], msip[0]); end
    endtask

    task automatic test_msip();
        logic [31:0] rd, d;
        logic        ak, er;
        d = $urandom;
        bus(0, 1'b1, 5'h00, d | 32'd1, 4'hf, rd, ak, er);
        vecs++; if (ak !== 1'b1 || msip[0] !== 1'b1) begin errs++; $display("FAIL msip_set: got ack=%b msip=%b want 1/1", ak, msip[0]); end
        @(posedge clk);
        #1;
        vecs++; if (ack[0] !== 1'b0) begin errs++; $display("FAIL ack_pulse: got %b want 0", ack[0]); end
        bus(0, 1'b0, 5'h00, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'h1) begin errs++; $display("FAIL msip_read1: got %h want 00000001", rd); end
        bus(0, 1'b1, 5'h00, d & ~32'd1, 4'hf, rd, ak, er);
        vecs++; if (msip[0] !== 1'b0) begin errs++; $display("FAIL msip_clr: got %b want 0", msip[0]); end
        bus(0, 1'b0, 5'h00, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL msip_read0: got %h want 0", rd); end
    endtask

    task automatic test_timer_cmp();
        logic [31:0] rd;
        logic        ak, er, found;
        found = 1'b0;
        bus(0, 1'b1, 5'h0c, 32'd0, 4'hf, rd, ak, er);
        bus(0, 1'b1, 5'h14, 32'd0, 4'hf, rd, ak, er);
        bus(0, 1'b1, 5'h10, 32'd0, 4'hf, rd, ak, er);
        bus(0, 1'b1, 5'h08, 32'h20, 4'hf, rd, ak, er);
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk);
            #1;
            if (mtip[0] === 1'b1) begin
                found = 1'b1;
                // mtime became 0x20 on the previous edge, so it now reads 0x21.
                vecs++; if (m_mtime[0] !== 64'h21) begin errs++; $display("FAIL mtip_rise_time: got mtime %h want 21", m_mtime[0]); end
            end
        end
        vecs++; if (found !== 1'b1) begin errs++; $display("FAIL mtip_rise: got no rise want rise within 200 cycles"); end
        bus(0, 1'b1, 5'h08, 32'hffff_ffff, 4'hf, rd, ak, er);
        vecs++; if (mtip[0] !== 1'b1) begin errs++; $display("FAIL mtip_hold: got %b want 1", mtip[0]); end
        @(posedge clk);
        #1;
        vecs++; if (mtip[0] !== 1'b0) begin errs++; $display("FAIL mtip_drop: got %b want 0", mtip[0]); end
    endtask

    task automatic test_carry();
        logic [31:0] rd;
        logic        ak, er;
        bus(0, 1'b1, 5'h10, 32'hffff_fffe, 4'hf, rd, ak, er);
        bus(0, 1'b1, 5'h14, 32'd0, 4'hf, rd, ak, er);
        bus(0, 1'b0, 5'h14, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'd1) begin errs++; $display("FAIL carry_hi: got %h want 1", rd); end
        bus(0, 1'b0, 5'h10, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'd2) begin errs++; $display("FAIL carry_lo: got %h want 2", rd); end
        bus(0, 1'b1, 5'h14, 32'hffff_ffff, 4'hf, rd, ak, er);
        bus(0, 1'b1, 5'h10, 32'hffff_fffe, 4'hf, rd, ak, er);
        bus(0, 1'b0, 5'h14, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'hffff_ffff) begin errs++; $display("FAIL ones_hi: got %h want ffffffff", rd); end
        bus(0, 1'b0, 5'h10, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'd1) begin errs++; $display("FAIL wrap_lo: got %h want 1", rd); end
        bus(0, 1'b0, 5'h14, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL wrap_hi: got %h want 0", rd); end
    endtask

    task automatic test_tick_div();
        logic [31:0] rd, r0, r2, d, prev;
        logic        ak, er;
        bus(1, 1'b0, 5'h10, 32'd0, 4'hf, r0, ak, er);
        bus(1, 1'b0, 5'h10, 32'd0, 4'hf, rd, ak, er);
        bus(1, 1'b0, 5'h10, 32'd0, 4'hf, r2, ak, er);
        vecs++; if (r2 - r0 !== 32'd1) begin errs++; $display("FAIL div4_rate: got delta %0d want 1", r2 - r0); end
        // Advance until the coming edge is a tick of the divide-by-4 instance.
        for (int k = 0; k < 8 && (m_cyc[1] % 4) != 3; k++) begin
            @(posedge clk);
            #1;
        end
        bus(1, 1'b1, 5'h10, 32'h100, 4'hf, rd, ak, er);
        bus(1, 1'b0, 5'h10, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'h100) begin errs++; $display("FAIL tick_write: got %h want 00000100", rd); end
        bus(1, 1'b0, 5'h10, 32'd0, 4'hf, rd, ak, er);
        bus(1, 1'b0, 5'h10, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'h101) begin errs++; $display("FAIL tick_resume: got %h want 00000101", rd); end
        prev = m_cmp[1][31:0];
        d = $urandom;
        d[7:0] = 8'hab;
        bus(1, 1'b1, 5'h08, d, 4'b0001, rd, ak, er);
        bus(1, 1'b0, 5'h08, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== {prev[31:8], 8'hab}) begin errs++; $display("FAIL lane_mask: got %h want %h", rd, {prev[31:8], 8'hab}); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, cmp_lo, d;
        logic        ak, er, ms;
        cmp_lo = m_cmp[0][31:0];
        ms = m_msip[0];
        d = $urandom;
        bus(0, 1'b1, 5'h18, d, 4'hf, rd, ak, er);
        vecs++; if (er !== 1'b1 || ak !== 1'b0 || rd !== 32'd0) begin errs++; $display("FAIL unmapped_wr: got err=%b ack=%b dat=%h want 1/0/0", er, ak, rd); end
        @(posedge clk);
        #1;
        vecs++; if (err[0] !== 1'b0) begin errs++; $display("FAIL err_pulse: got %b want 0", err[0]); end
        bus(0, 1'b0, 5'h18, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (er !== 1'b1 || ak !== 1'b0 || rd !== 32'd0) begin errs++; $display("FAIL unmapped_rd: got err=%b ack=%b dat=%h want 1/0/0", er, ak, rd); end
        bus(0, 1'b1, 5'h04, d, 4'hf, rd, ak, er);
        vecs++; if (er !== 1'b1 || ak !== 1'b0) begin errs++; $display("FAIL unmapped_w1: got err=%b ack=%b want 1/0", er, ak); end
        bus(0, 1'b0, 5'h08, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== cmp_lo) begin errs++; $display("FAIL unmapped_side: got %h want %h", rd, cmp_lo); end
        bus(0, 1'b0, 5'h00, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== {31'd0, ms}) begin errs++; $display("FAIL unmapped_msip: got %h want %h", rd, {31'd0, ms}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        ak, er;
        bus(0, 1'b1, 5'h00, 32'd1, 4'hf, rd, ak, er);
        bus(0, 1'b1, 5'h0c, 32'h1234, 4'hf, rd, ak, er);
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we_s[0] = 1'b0; adr[0] = 5'h0c; sel[0] = 4'hf;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vecs++; if (ack[0] !== 1'b0 || err[0] !== 1'b0) begin errs++; $display("FAIL rst_drop: got ack=%b err=%b want 0/0", ack[0], err[0]); end
        vecs++; if (msip[0] !== 1'b0) begin errs++; $display("FAIL rst_msip: got %b want 0", msip[0]); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vecs++; if (ack[0] !== 1'b1 || dato[0] !== 32'hffff_ffff) begin errs++; $display("FAIL rst_serve: got ack=%b dat=%h want 1/ffffffff", ack[0], dato[0]); end
        @(negedge clk);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        bus(1, 1'b0, 5'h10, 32'd0, 4'hf, rd, ak, er);
        vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL rst_mtime_div4: got %h want 0", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d;
        logic [3:0]  s;
        logic [2:0]  idx;
        logic [1:0]  lo2;
        logic        ak, er, wr;
        int          w;
        for (int n = 0; n < 300; n++) begin
            w   = int'($urandom_range(0, 1));
            idx = 3'($urandom_range(0, 7));
            wr  = 1'($urandom_range(0, 1));
            s   = 4'($urandom);
            lo2 = 2'($urandom);
            d   = $urandom;
            if (idx == 3'd2) d = m_mtime[w][31:0] + 32'($urandom_range(0, 24));
            if (idx == 3'd3) d = m_mtime[w][63:32];
            repeat ($urandom_range(0, 3)) @(posedge clk);
            bus(w, wr, {idx, lo2}, d, s, rd, ak, er);
            vecs++; if (ak !== m_ack[w] || er !== m_err[w]) begin errs++; $display("FAIL rnd_resp dut%0d: got ack=%b err=%b want %b/%b", w, ak, er, m_ack[w], m_err[w]); end
            vecs++; if (rd !== m_rdata[w]) begin errs++; $display("FAIL rnd_data dut%0d idx%0d: got %h want %h", w, idx, rd, m_rdata[w]); end
            vecs++; if (mtip[w] !== m_mtip[w] || mtip[1-w] !== m_mtip[1-w]) begin errs++; $display("FAIL rnd_mtip: got %b want %b%b", mtip, m_mtip[1], m_mtip[0]); end
            vecs++; if (msip[w] !== m_msip[w]) begin errs++; $display("FAIL rnd_msip dut%0d: got %b want %b", w, msip[w], m_msip[w]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        cyc = '0; stb = '0; we_s = '0;
        for (int w = 0; w < 2; w++) begin
            adr[w] = '0; wdat[w] = '0; sel[w] = '0;
        end
        test_reset();
        test_msip();
        test_timer_cmp();
        test_carry();
        test_tick_div();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end
endmodule
